// File: rtl/freq_pkg.sv
// freq_pkg -- shared constants for the selectable-rate square-wave generator.
//   Rate table: index 0..3 selects 1 / 2 / 5 / 10 Hz; hp_calc() turns an
//   index into a half-period length in clock cycles for a given clock rate.
//   Also holds the scheduler state encoding and the auto-step tick budget.
package freq_pkg;

  localparam int NUM_RATES  = 4;
  localparam int RATE_W     = $clog2(NUM_RATES);
  localparam int AUTO_TICKS = 16;
  localparam int TCNT_W     = $clog2(AUTO_TICKS);
  localparam int CNT_W      = 25;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_PEND = 1'b1;

  // Half-period length in cycles for rate index idx at clock clk_hz.
  function automatic logic [CNT_W-1:0] hp_calc(input int unsigned clk_hz,
                                               input int unsigned idx);
    int unsigned hz;
    case (idx)
      0:       hz = 1;
      1:       hz = 2;
      2:       hz = 5;
      default: hz = 10;
    endcase
    return CNT_W'(clk_hz / (2 * hz));
  endfunction

endpackage

// File: rtl/freq_sched_debounce.sv
// debounce -- 2-flop synchroniser, stability filter and press detector.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_raw   : asynchronous raw button level
//   o_press : one-cycle pulse after each debounced 0->1 transition
module debounce #(
  parameter int DB_CYC = 500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      // r_cnt holds how many consecutive earlier cycles disagreed with the
      // debounced level; the level flips on the DB_CYC-th disagreeing cycle.
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_CYC - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
        r_press <= r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/freq_sched.sv
// freq_sched -- square-wave generator with four selectable rates.
//   clkfreq  : clock, all logic on the rising edge
//   rst      : synchronous active-high reset
//   sw       : raw mode switch (0 = manual stepping, 1 = auto stepping)
//   btn      : raw push-button; each debounced press steps the rate (manual)
//   rate_sel : active rate index (0 = 1 Hz, 1 = 2 Hz, 2 = 5 Hz, 3 = 10 Hz)
//   tick     : one-cycle pulse after each half-period boundary
//   outfreq  : 50% duty square wave at the active rate
// Rate changes only take effect on a half-period boundary so outfreq never
// produces a runt pulse.
module freq_sched
  import freq_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DB_CYC = 500_000
) (
  input  logic       clkfreq,
  input  logic       rst,
  input  logic       sw,
  input  logic       btn,
  output logic [1:0] rate_sel,
  output logic       tick,
  output logic       outfreq
);

  localparam logic [CNT_W-1:0] HP0 = hp_calc(CLK_HZ, 0);
  localparam logic [CNT_W-1:0] HP1 = hp_calc(CLK_HZ, 1);
  localparam logic [CNT_W-1:0] HP2 = hp_calc(CLK_HZ, 2);
  localparam logic [CNT_W-1:0] HP3 = hp_calc(CLK_HZ, 3);

  logic              r_sw_s1;
  logic              r_sw_s2;
  logic              w_press;
  logic              w_auto;
  logic              w_man_press;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_hp;
  logic              w_bnd;
  logic              r_tick;
  logic              r_out;
  logic [RATE_W-1:0] r_rate;
  logic [RATE_W-1:0] r_pend;
  logic              r_state;
  logic [TCNT_W-1:0] r_tcnt;

  debounce #(.DB_CYC(DB_CYC)) u_btn_db (
    .i_clk   (clkfreq),
    .i_rst   (rst),
    .i_raw   (btn),
    .o_press (w_press)
  );

  // The mode switch only needs synchronising; it is a level, not an event.
  always_ff @(posedge clkfreq) begin
    if (rst) begin
      r_sw_s1 <= 1'b0;
      r_sw_s2 <= 1'b0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  assign w_auto      = r_sw_s2;
  assign w_man_press = w_press & ~w_auto;

  always_comb begin
    w_hp = HP3;
    case (r_rate)
      2'd0:    w_hp = HP0;
      2'd1:    w_hp = HP1;
      2'd2:    w_hp = HP2;
      default: w_hp = HP3;
    endcase
  end

  assign w_bnd = (r_cnt == w_hp - CNT_W'(1));

  // Half-period counter; it is never disturbed by mode changes.
  always_ff @(posedge clkfreq) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_out  <= 1'b0;
    end else begin
      r_tick <= w_bnd;
      if (w_bnd) begin
        r_cnt <= '0;
        r_out <= ~r_out;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Rate scheduler. A pending manual change wins over auto stepping at a
  // boundary; a press landing on that same boundary re-arms PEND relative to
  // the index being applied, so it is never lost.
  always_ff @(posedge clkfreq) begin
    if (rst) begin
      r_rate  <= '0;
      r_pend  <= '0;
      r_state <= ST_RUN;
      r_tcnt  <= '0;
    end else if (w_bnd && (r_state == ST_PEND)) begin
      r_rate <= r_pend;
      r_tcnt <= '0;
      if (w_man_press) begin
        r_pend <= r_pend + RATE_W'(1);
      end else begin
        r_state <= ST_RUN;
      end
    end else begin
      if (w_man_press) begin
        if (r_state == ST_RUN) begin
          r_pend  <= r_rate + RATE_W'(1);
          r_state <= ST_PEND;
        end else begin
          r_pend <= r_pend + RATE_W'(1);
        end
      end
      if (!w_auto) begin
        r_tcnt <= '0;
      end else if (w_bnd) begin
        if (r_tcnt == TCNT_W'(AUTO_TICKS - 1)) begin
          r_rate <= r_rate + RATE_W'(1);
          r_tcnt <= '0;
        end else begin
          r_tcnt <= r_tcnt + TCNT_W'(1);
        end
      end
    end
  end

  assign rate_sel = r_rate;
  assign tick     = r_tick;
  assign outfreq  = r_out;

endmodule

// File: tb/tb_freq_sched.sv
module tb_freq_sched;

  localparam int CLK_HZ = 200;
  localparam int DB_CYC = 4;
  localparam int MAXE   = 40000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw  = 1'b0;
  logic       btn = 1'b0;
  logic [1:0] rate_sel;
  logic       tick;
  logic       outfreq;

  freq_sched #(.CLK_HZ(CLK_HZ), .DB_CYC(DB_CYC)) dut (
    .clkfreq  (clk),
    .rst      (rst),
    .sw       (sw),
    .btn      (btn),
    .rate_sel (rate_sel),
    .tick     (tick),
    .outfreq  (outfreq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int rate_hz [4] = '{1, 2, 5, 10};
  function automatic int hp(int r);
    return CLK_HZ / (2 * rate_hz[r]);
  endfunction

  bit bh [MAXE];
  bit sh [MAXE];
  int e;
  bit lvl, press_q, pending, m_out, seen_edge;
  int pend, m_rate, tcount, next_b;

  typedef struct {
    int rate;
    bit out;
  } exp_t;
  exp_t sbq[$];

  function automatic bit bsamp(int k);
    return (k < 1) ? 1'b0 : bh[k];
  endfunction

  always @(posedge clk) begin : model
    bit press, auto_m, bnd, all_diff, old_pending;
    int old_pend, old_rate;
    seen_edge = 1'b1;
    if (rst) begin
      e = 0; lvl = 0; press_q = 0; pending = 0; pend = 0;
      m_rate = 0; tcount = 0; m_out = 0; next_b = hp(0);
      sbq.delete();
    end else begin
      e++;
      if (e < MAXE) begin
        bh[e] = btn;
        sh[e] = sw;
      end
      // press event seen by the scheduler this edge (debounced rise one edge ago)
      press   = press_q;
      press_q = 0;
      // debounced level flips once the last DB_CYC synchronised samples all disagree
      all_diff = 1;
      for (int k = 2; k <= DB_CYC + 1; k++)
        if (bsamp(e - k) == lvl) all_diff = 0;
      if (all_diff) begin
        lvl     = !lvl;
        press_q = lvl;
      end
      auto_m = (e - 2 >= 1) ? sh[e - 2] : 1'b0;
      bnd    = (e == next_b);

      old_pending = pending;
      old_pend    = pend;
      old_rate    = m_rate;
      if (bnd) begin
        if (old_pending) begin
          m_rate  = old_pend;
          tcount  = 0;
          pending = 0;
        end else if (auto_m) begin
          tcount++;
          if (tcount == 16) begin
            m_rate = (m_rate + 1) % 4;
            tcount = 0;
          end
        end else begin
          tcount = 0;
        end
      end else if (!auto_m) begin
        tcount = 0;
      end
      if (press && !auto_m) begin
        pend    = ((old_pending ? old_pend : old_rate) + 1) % 4;
        pending = 1;
      end
      if (bnd) begin
        m_out  = !m_out;
        sbq.push_back('{m_rate, m_out});
        next_b = e + hp(m_rate);
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t x;
    if (seen_edge) begin
      if (tick === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_tick", tick, 0);
        end else begin
          x = sbq.pop_front();
          check("tick_rate", rate_sel, x.rate);
          check("tick_outfreq", outfreq, x.out);
        end
      end else if (sbq.size() != 0) begin
        x = sbq.pop_front();
        check("missing_tick", tick, 1);
      end
      check("rate_sel", rate_sel, m_rate);
      check("outfreq", outfreq, m_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(n);
    rst = 1'b0;
  endtask

  initial begin
    int run_left;
    // basic 1 Hz operation
    cyc(3);
    rst = 1'b0;
    cyc(99);
    check("r029_tick_before", tick, 0);
    cyc(1);
    check("r029_tick_first", tick, 1);
    check("r029_out_first", outfreq, 1);
    check("r029_rate", rate_sel, 0);
    cyc(100);
    check("r029_tick_second", tick, 1);
    check("r029_out_second", outfreq, 0);
    cyc(120);

    // one press, applied at the first boundary
    do_reset(2);
    cyc(30);
    btn = 1'b1;
    cyc(10);
    btn = 1'b0;
    cyc(59);
    check("r030_rate_pre", rate_sel, 0);
    cyc(1);
    check("r030_rate_post", rate_sel, 1);
    check("r030_tick", tick, 1);
    cyc(50);
    check("r030_tick_2hz", tick, 1);
    cyc(100);

    // bouncing button never settles long enough
    do_reset(2);
    cyc(10);
    repeat (5) begin
      btn = 1'b1; cyc(2);
      btn = 1'b0; cyc(2);
    end
    cyc(250);
    check("r031_rate", rate_sel, 0);

    // four presses wrap back to the current rate
    do_reset(2);
    cyc(5);
    repeat (4) begin
      btn = 1'b1; cyc(5);
      btn = 1'b0; cyc(5);
    end
    cyc(55);
    check("r032_rate_bnd", rate_sel, 0);
    check("r032_tick", tick, 1);
    cyc(100);
    check("r032_rate_next", rate_sel, 0);
    cyc(20);

    // auto stepping from reset, with ignored presses
    sw = 1'b1;
    do_reset(2);
    for (int k = 1; k <= 2885; k++) begin
      btn = (k > 50) && ((k % 200) < 8);
      cyc(1);
      case (k)
        1599: check("r033_r0_hold", rate_sel, 0);
        1600: check("r033_to1", rate_sel, 1);
        2399: check("r033_r1_hold", rate_sel, 1);
        2400: check("r033_to2", rate_sel, 2);
        2719: check("r033_r2_hold", rate_sel, 2);
        2720: check("r033_to3", rate_sel, 3);
        2879: check("r033_r3_hold", rate_sel, 3);
        2880: check("r033_to0", rate_sel, 0);
        default: ;
      endcase
    end
    btn = 1'b0;
    sw  = 1'b0;

    // reset while a change is pending
    do_reset(2);
    cyc(130);
    btn = 1'b1;
    cyc(8);
    btn = 1'b0;
    cyc(50);
    rst = 1'b1;
    cyc(1);
    check("r034_rate", rate_sel, 0);
    check("r034_out", outfreq, 0);
    check("r034_tick", tick, 0);
    rst = 1'b0;
    cyc(99);
    check("r034_tick_pre", tick, 0);
    cyc(1);
    check("r034_tick_first", tick, 1);
    check("r034_rate_kept", rate_sel, 0);
    cyc(20);

    // randomized mix of presses, bounces, mode flips and resets
    do_reset(2);
    run_left = 0;
    for (int k = 0; k < 6000; k++) begin
      if (run_left == 0) begin
        btn      = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 12);
      end
      run_left--;
      if ($urandom_range(0, 799) == 0) sw = ~sw;
      if ($urandom_range(0, 2999) == 0) rst = 1'b1;
      cyc(1);
      rst = 1'b0;
    end
    btn = 1'b0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_sched.md
FREQ_SCHED -- requirements
Module: freq_sched

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter DB_CYC, default 500_000, number of stable cycles required by the button debouncer (10 ms at 50 MHz).
REQ-003 clkfreq  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 sw  in  1  raw mode switch; 0 = manual stepping, 1 = auto stepping.
REQ-006 btn  in  1  raw push-button; a debounced press steps the rate in manual mode.
REQ-007 rate_sel  out  2  index of the active rate: 0 = 1 Hz, 1 = 2 Hz, 2 = 5 Hz, 3 = 10 Hz.
REQ-008 tick  out  1  one-cycle pulse at each half-period boundary of the active rate.
REQ-009 outfreq  out  1  square wave at the active rate, 50% duty.

Function
REQ-010 Half-period count HP[i] = CLK_HZ / (2 * rate_i); the counter shall be 25 bits wide, enough for HP[0] = 25_000_000 at the default CLK_HZ.
REQ-011 The counter shall count 0..HP[rate_sel]-1; at the edge where it equals HP-1, the block shall:
- set the counter to 0;
- register tick = 1 for exactly one cycle;
- toggle outfreq.
REQ-012 First tick is high during the cycle following the HP[0]-th rising edge after rst deasserts.
REQ-013 sw and btn shall each pass through a 2-flop synchroniser; btn is then debounced.
REQ-014 The debounced level shall change only after the synchronised input has been stable for DB_CYC consecutive cycles; a debounced 0->1 transition is one press event.
REQ-015 The FSM shall have two states: RUN (no change pending) and PEND (a new index is held in a pend register).
REQ-016 In manual mode (synchronised sw = 0), a press event in RUN shall set pend = rate_sel + 1 (mod 4) and move the FSM to PEND.
REQ-017 A press in PEND shall set pend = pend + 1 (mod 4); presses accumulate with wrap 3->0.
REQ-018 Rate changes are glitch-free. In PEND, at the next half-period boundary (REQ-011):
- rate_sel <= pend;
- FSM -> RUN;
- the following half-period uses the new HP.
REQ-019 A press event on the same edge as a boundary shall be captured into pend and applied at the next boundary, never dropped.
REQ-020 In auto mode (synchronised sw = 1), press events shall be ignored.
REQ-021 In auto mode, a 4-bit tick counter shall count boundaries at the current rate; at the 16th boundary (8 full periods):
- rate_sel <= rate_sel + 1 (mod 4) on that same edge;
- the tick counter clears.
REQ-022 The tick counter shall clear on any rate change and while in manual mode.
REQ-023 A pending manual change in PEND when sw goes to 1 shall still be applied at the next boundary; auto counting restarts from 0 after it.
REQ-024 The rate counter shall free-run across mode switches; changing sw shall not reset the counter or outfreq.

Reset
REQ-025 While rst = 1, at each edge the block shall set:
- rate_sel = 0, tick = 0, outfreq = 0;
- counter = 0, tick counter = 0, pend = 0, FSM = RUN;
- synchroniser and debouncer flops = 0, debounce counter = 0.
REQ-026 Reset mid-PEND shall discard the pending change; no press event shall be generated by reset release while btn is held low.

Structure
REQ-027 Shared package freq_pkg shall hold:
- the rate table (HP constants derived from CLK_HZ);
- NUM_RATES = 4;
- the RUN/PEND state encoding;
- AUTO_TICKS = 16.
REQ-028 The debouncer (synchroniser, stability counter, rising-edge press pulse) shall be one sub-module named debounce; rate counter and FSM stay in freq_sched.

Verification
Bench parameters: CLK_HZ = 200 and DB_CYC = 4, giving HP = 100 / 50 / 20 / 10.
REQ-029 Reset release, sw = 0, btn = 0 -> tick pulses 100 cycles apart; outfreq toggles on each; rate_sel = 0.
REQ-030 btn high for 10 cycles starting 30 cycles after reset release -> rate_sel stays 0 until the first boundary (100 cycles after release), then 1; next tick 50 cycles later.
REQ-031 btn toggling every 2 cycles for 20 cycles, then held low -> no press event; rate_sel unchanged; FSM stays RUN.
REQ-032 Four clean presses within one half-period -> pend wraps to 0; at the boundary rate_sel remains 0; FSM returns to RUN.
REQ-033 sw = 1 from reset -> rate_sel goes 0 -> 1 after 16 ticks (1600 cycles); 1 -> 2 after 800 more; 2 -> 3 after 320 more; 3 -> 0 after 160 more. btn presses during this have no effect.
REQ-034 Press, then rst asserted for 1 cycle before the boundary -> all outputs 0, rate_sel = 0; after release, first tick at 100 cycles with no pending change applied.
